cache_mem_responder: RTL and testbench

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

---
 rtl/cache_mem_responder_if.sv | 32 +++
 rtl/cache_mem_responder.sv | 146 ++++++++++++++
 tb/tb_cache_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// Cache <-> memory responder bus: request channel, load beat channel,
// writeback beat channel and the responder status outputs.
interface cache_mem_responder_if #(
   parameter int ADDR_SIZE      = 32,
   parameter int DATA_SIZE      = 32,
   parameter int WR_M_DATA_SIZE = 4
);
   logic                                      addr_valid_out;
   logic [ADDR_SIZE-1:0]                      addr_out_m;
   logic                                      rw_out;
   logic                                      ready_ld;
   logic                                      valid_ld;
   logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0]  data_in_m;
   logic                                      valid_wb;
   logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0]  data_out_m;
   logic                                      ready_wb;
   logic                                      busy;
   logic [15:0]                               fill_count;
   logic [15:0]                               wb_count;

   // cache side
   modport master (
      output addr_valid_out, addr_out_m, rw_out, ready_ld, valid_wb, data_out_m,
      input  valid_ld, data_in_m, ready_wb, busy, fill_count, wb_count
   );

   // memory responder side
   modport slave (
      input  addr_valid_out, addr_out_m, rw_out, ready_ld, valid_wb, data_out_m,
      output valid_ld, data_in_m, ready_wb, busy, fill_count, wb_count
   );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder for a cache: serves line fills (stored data if the
// line was written back, otherwise an address-derived pattern) and absorbs
// line writebacks into a direct-indexed line store.
module cache_mem_responder #(
   parameter int ADDR_SIZE      = 32,
   parameter int DATA_SIZE      = 32,
   parameter int BLOCK_SIZE     = 6,
   parameter int WR_M_DATA_SIZE = 4,
   parameter int DEPTH_LOG2     = 8,
   parameter int LATENCY        = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   cache_mem_responder_if.slave  bus
);
   localparam int BEATS = (2**BLOCK_SIZE) / WR_M_DATA_SIZE;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LINES = 2**DEPTH_LOG2;
   localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef logic [WR_M_DATA_SIZE-1:0][DATA_SIZE-1:0] beat_t;
   typedef enum logic [2:0] {IDLE, LAT, LOAD, WB, DONE} state_t;

   state_t                 state_q;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic [BW-1:0]          beat_q;
   logic [LW-1:0]          lat_q;
   logic                   valid_ld_q;
   logic                   ready_wb_q;
   logic                   busy_q;
   beat_t                  data_q;
   logic [15:0]            fill_q;
   logic [15:0]            wb_q;
   logic [LINES-1:0]       line_vld_q;
   beat_t                  mem_q [LINES][BEATS];

   logic [DEPTH_LOG2-1:0]  line_q;
   logic                   last_beat;
   logic [ADDR_SIZE-1:0]   ld_addr_d;
   logic [ADDR_SIZE-1:0]   ld_base_d;
   logic [DEPTH_LOG2-1:0]  ld_line_d;
   logic [BW-1:0]          ld_beat_d;
   beat_t                  ld_data_d;

   assign line_q    = addr_q[BLOCK_SIZE +: DEPTH_LOG2];
   assign last_beat = (beat_q == BW'(BEATS-1));

   // Next load beat to present: in IDLE the request is still on the bus, so
   // read straight from it; otherwise from the captured address.
   always_comb begin
      ld_addr_d = (state_q == IDLE) ? bus.addr_out_m : addr_q;
      ld_beat_d = (state_q == LOAD) ? beat_q + 1'b1 : '0;
      ld_line_d = ld_addr_d[BLOCK_SIZE +: DEPTH_LOG2];
      ld_base_d = ld_addr_d & ~ADDR_SIZE'((1 << BLOCK_SIZE) - 1);
      ld_data_d = '0;
      if (line_vld_q[ld_line_d]) begin
         ld_data_d = mem_q[ld_line_d][ld_beat_d];
      end else begin
         for (int w = 0; w < WR_M_DATA_SIZE; w++)
            ld_data_d[w] = DATA_SIZE'(ld_base_d + ADDR_SIZE'(ld_beat_d) * ADDR_SIZE'(WR_M_DATA_SIZE)
                                      + ADDR_SIZE'(w));
      end
   end

   // Line store write port; only WB accepts beats, stray valid_wb elsewhere is dropped.
   always_ff @(posedge clk) begin
      if (state_q == WB && bus.valid_wb)
         mem_q[line_q][beat_q] <= bus.data_out_m;
   end

   // Transaction FSM with registered handshake outputs and completion counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         beat_q     <= '0;
         lat_q      <= '0;
         valid_ld_q <= 1'b0;
         ready_wb_q <= 1'b0;
         busy_q     <= 1'b0;
         data_q     <= '0;
         fill_q     <= '0;
         wb_q       <= '0;
         line_vld_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.addr_valid_out) begin
               addr_q <= bus.addr_out_m;
               beat_q <= '0;
               lat_q  <= '0;
               busy_q <= 1'b1;
               if (bus.rw_out) begin
                  state_q    <= WB;
                  ready_wb_q <= 1'b1;
               end else if (LATENCY == 0) begin
                  state_q    <= LOAD;
                  valid_ld_q <= 1'b1;
                  data_q     <= ld_data_d;
               end else begin
                  state_q <= LAT;
               end
            end
            LAT: if (lat_q == LW'(LATENCY-1)) begin
               state_q    <= LOAD;
               valid_ld_q <= 1'b1;
               data_q     <= ld_data_d;
            end else begin
               lat_q <= lat_q + 1'b1;
            end
            LOAD: if (bus.ready_ld) begin
               if (last_beat) begin
                  valid_ld_q <= 1'b0;
                  fill_q     <= fill_q + 16'd1;
                  state_q    <= DONE;
               end else begin
                  beat_q <= beat_q + 1'b1;
                  data_q <= ld_data_d;
               end
            end
            WB: if (bus.valid_wb) begin
               if (last_beat) begin
                  ready_wb_q         <= 1'b0;
                  line_vld_q[line_q] <= 1'b1;
                  wb_q               <= wb_q + 16'd1;
                  state_q            <= DONE;
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            // Wait for the request to drop so a held request is not replayed.
            DONE: if (!bus.addr_valid_out) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.valid_ld   = valid_ld_q;
   assign bus.data_in_m  = data_q;
   assign bus.ready_wb   = ready_wb_q;
   assign bus.busy       = busy_q;
   assign bus.fill_count = fill_q;
   assign bus.wb_count   = wb_q;
endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized scoreboard bench for cache_mem_responder: a line-level model
// predicts every load beat, a monitor pops and compares accepted beats.
module tb_cache_mem_responder;
   localparam int AW = 32, DW = 32, W = 4, BS = 6, BEATS = 16, LAT = 2;
   localparam int W2 = 8, BEATS2 = 8;

   typedef logic [W-1:0][DW-1:0]  beat_t;
   typedef logic [W2-1:0][DW-1:0] beat2_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_mem_responder_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .WR_M_DATA_SIZE(W))  bus ();
   cache_mem_responder_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .WR_M_DATA_SIZE(W2)) bus2 ();

   cache_mem_responder #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS),
      .WR_M_DATA_SIZE(W), .DEPTH_LOG2(8), .LATENCY(LAT))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   cache_mem_responder #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS),
      .WR_M_DATA_SIZE(W2), .DEPTH_LOG2(8), .LATENCY(0))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   int total = 0;
   int bad = 0;

   // reference model: written lines keyed by line index, plus expected counters
   beat_t mdl_mem [int];
   bit    mdl_vld [int];
   int    exp_fill = 0;
   int    exp_wb = 0;
   beat_t sbq [$];
   bit    stall_pend = 1'b0;
   beat_t stall_data;

   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] patw(logic [31:0] a, int b, int w, int wpb);
      return (a & ~32'h3F) + 32'(b * wpb + w);
   endfunction

   function automatic int line_of(logic [31:0] a);
      return int'((a >> BS) & 32'hFF);
   endfunction

   function automatic beat_t exp_beat(logic [31:0] a, int b);
      beat_t r;
      int ln;
      ln = line_of(a);
      if (mdl_vld.exists(ln)) return mdl_mem[ln*BEATS + b];
      for (int w = 0; w < W; w++) r[w] = patw(a, b, w, W);
      return r;
   endfunction

   function automatic beat_t rnd_beat();
      beat_t r;
      for (int w = 0; w < W; w++) r[w] = $urandom;
      return r;
   endfunction

   // Monitor: compare every accepted load beat and data stability across stalls.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (stall_pend && bus.valid_ld) chk("stall_hold", bus.data_in_m, stall_data);
         stall_pend = 1'b0;
         if (bus.valid_ld && bus.ready_ld) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat got=%0h want=none", bus.data_in_m);
            end else begin
               chk("ld_beat", bus.data_in_m, sbq.pop_front());
            end
         end else if (bus.valid_ld) begin
            stall_pend = 1'b1;
            stall_data = bus.data_in_m;
         end
      end
   end

   // noise on inputs that the current state must ignore
   task automatic junk(bit hold);
      bus.valid_wb   = 1'($urandom);
      bus.data_out_m = rnd_beat();
      if (hold) begin
         bus.addr_out_m = $urandom;
         bus.rw_out     = 1'($urandom);
      end
   endtask

   task automatic finish_txn(bit hold);
      if (hold) begin
         repeat (4) begin
            @(negedge clk);
            junk(1'b1);
         end
         chk("hold_busy", bus.busy, 1);
         chk("hold_no_ld", bus.valid_ld, 0);
         chk("hold_no_wb", bus.ready_wb, 0);
         chk("hold_fill", bus.fill_count, 16'(exp_fill));
         chk("hold_wbcnt", bus.wb_count, 16'(exp_wb));
         bus.addr_valid_out = 1'b0;
      end
      @(negedge clk);
      bus.valid_wb = 1'b0;
      chk("idle_busy", bus.busy, 0);
   endtask

   task automatic issue(logic [31:0] a, bit rw, bit hold);
      @(negedge clk);
      bus.addr_valid_out = 1'b1;
      bus.addr_out_m     = a;
      bus.rw_out         = rw;
      @(negedge clk);
      if (!hold) bus.addr_valid_out = 1'b0;
   endtask

   task automatic run_load(logic [31:0] a, bit hold, int mode);
      int n, acc, cyc;
      for (int b = 0; b < BEATS; b++) sbq.push_back(exp_beat(a, b));
      exp_fill++;
      issue(a, 1'b0, hold);
      n = 1;
      while (!bus.valid_ld && n < 20) begin
         junk(hold);
         @(negedge clk);
         n++;
      end
      chk("ld_latency", n, LAT + 1);
      acc = 0;
      cyc = 0;
      while (acc < BEATS && cyc < 400) begin
         case (mode)
            0:       bus.ready_ld = 1'b1;
            1:       bus.ready_ld = (cyc % 2 == 0);
            default: bus.ready_ld = 1'($urandom);
         endcase
         junk(hold);
         if (bus.valid_ld && bus.ready_ld) acc++;
         @(negedge clk);
         cyc++;
      end
      bus.ready_ld = 1'($urandom);
      chk("ld_beats", acc, BEATS);
      chk("ld_done_vld", bus.valid_ld, 0);
      chk("done_busy", bus.busy, 1);
      chk("fill_count", bus.fill_count, 16'(exp_fill));
      sbq.delete();
      finish_txn(hold);
   endtask

   task automatic run_wb(logic [31:0] a, bit hold, bit directed);
      beat_t d [BEATS];
      int b, cyc, ln;
      bit v;
      for (int i = 0; i < BEATS; i++) begin
         if (directed) for (int w = 0; w < W; w++) d[i][w] = 32'hA000 + 32'(i);
         else d[i] = rnd_beat();
      end
      exp_wb++;
      issue(a, 1'b1, hold);
      b = 0;
      cyc = 0;
      while (b < BEATS && cyc < 400) begin
         v = ($urandom % 4) != 0;
         bus.valid_wb   = v;
         bus.data_out_m = d[b];
         bus.ready_ld   = 1'($urandom);
         if (hold) begin
            bus.addr_out_m = $urandom;
            bus.rw_out     = 1'($urandom);
         end
         if (bus.ready_wb && v) b++;
         @(negedge clk);
         cyc++;
      end
      bus.valid_wb   = 1'b1;
      bus.data_out_m = rnd_beat();
      chk("wb_beats", b, BEATS);
      chk("wb_done_rdy", bus.ready_wb, 0);
      chk("wb_count", bus.wb_count, 16'(exp_wb));
      ln = line_of(a);
      for (int i = 0; i < BEATS; i++) mdl_mem[ln*BEATS + i] = d[i];
      mdl_vld[ln] = 1'b1;
      finish_txn(hold);
   endtask

   task automatic reset_mid_load(logic [31:0] a);
      int n, acc, cyc;
      for (int b = 0; b < BEATS; b++) sbq.push_back(exp_beat(a, b));
      issue(a, 1'b0, 1'b0);
      n = 1;
      while (!bus.valid_ld && n < 20) begin
         @(negedge clk);
         n++;
      end
      acc = 0;
      cyc = 0;
      while (acc < 5 && cyc < 100) begin
         bus.ready_ld = 1'b1;
         if (bus.valid_ld) acc++;
         @(negedge clk);
         cyc++;
      end
      chk("rst_pre_beats", acc, 5);
      bus.ready_ld = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_vld", bus.valid_ld, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rdy", bus.ready_wb, 0);
      chk("rst_data", bus.data_in_m, 0);
      chk("rst_fill", bus.fill_count, 0);
      chk("rst_wbcnt", bus.wb_count, 0);
      sbq.delete();
      mdl_vld.delete();
      mdl_mem.delete();
      exp_fill = 0;
      exp_wb = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_lat0();
      int n, b, cyc;
      logic [31:0] a;
      beat2_t e;
      a = $urandom;
      @(negedge clk);
      bus2.addr_valid_out = 1'b1;
      bus2.addr_out_m     = a;
      bus2.rw_out         = 1'b0;
      bus2.ready_ld       = 1'b1;
      @(negedge clk);
      bus2.addr_valid_out = 1'b0;
      n = 1;
      while (!bus2.valid_ld && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("l0_latency", n, 1);
      b = 0;
      cyc = 0;
      while (bus2.valid_ld && cyc < 50) begin
         for (int w = 0; w < W2; w++) e[w] = patw(a, b, w, W2);
         chk("l0_beat", bus2.data_in_m, e);
         b++;
         @(negedge clk);
         cyc++;
      end
      chk("l0_beats", b, BEATS2);
      chk("l0_fill", bus2.fill_count, 1);
   endtask

   initial begin
      logic [7:0] lines [4];
      logic [31:0] a;
      lines = '{8'h48, 8'h01, 8'h02, 8'hFF};
      bus.addr_valid_out  = 1'b0;
      bus.addr_out_m      = '0;
      bus.rw_out          = 1'b0;
      bus.ready_ld        = 1'b0;
      bus.valid_wb        = 1'b0;
      bus.data_out_m      = '0;
      bus2.addr_valid_out = 1'b0;
      bus2.addr_out_m     = '0;
      bus2.rw_out         = 1'b0;
      bus2.ready_ld       = 1'b0;
      bus2.valid_wb       = 1'b0;
      bus2.data_out_m     = '0;
      #12;
      chk("reset_vld", bus.valid_ld, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_rdy", bus.ready_wb, 0);
      chk("reset_data", bus.data_in_m, 0);
      chk("reset_fill", bus.fill_count, 0);
      chk("reset_wbcnt", bus.wb_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_load(32'h0000_1234, 1'b0, 0);
      run_load(32'h0000_5678, 1'b0, 1);
      run_wb(32'h1000_1234, 1'b0, 1'b1);
      run_load(32'h1000_1234, 1'b0, 2);
      run_load(32'h0000_1234, 1'b1, 2);
      run_wb(32'h2000_0040, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         a = ($urandom & 32'hFFFF_C03F) | (32'(lines[$urandom % 4]) << BS);
         if ($urandom % 3 == 0) run_wb(a, ($urandom % 4) == 0, 1'b0);
         else run_load(a, ($urandom % 4) == 0, int'($urandom % 3));
      end
      reset_mid_load(32'h1000_1234);
      run_load(32'h1000_1234, 1'b0, 0);
      run_lat0();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
